idu_pipe: RTL and testbench
===========================

# idu_pipe

Parametrised decode stage with a ready/valid handshake on both sides and an internal decoded-instruction queue. It accepts 32-bit RV32I/RV64I(M) instructions from the fetch stage, decodes immediates, register indices, format and control flags, including RAS call/return hints and illegal-instruction detection. Decoded entries are buffered in a QDEPTH-entry FIFO so backpressure from execute never needs a combinational path to fetch. It sits between IFU and EXU and replaces the fixed 64-bit, always-advancing decoder.

## Interface
- XLEN, 64, datapath width; 32 or 64. Sets the imm/pc width and W-op legality.
- QDEPTH, 2, queue entries; power of two, ≥1.
- RESET_PC, 64'h80000000, reset value of out_pc, truncated to XLEN.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous discard of the queue and of the current input
- in_vld  in  1  fetch offers an instruction
- in_rdy  out  1  decode can accept
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_vld  out  1  head entry valid
- out_rdy  in  1  execute consumes the head entry
- out_pc  out  XLEN  pc of the head entry
- out_inst  out  32  raw instruction of the head entry
- out_rd, out_rs1, out_rs2  out  5 each  register indices, inst[11:7], inst[19:15], inst[24:20]
- out_imm  out  XLEN  sign-extended immediate, 0 for R-type
- out_fmt  out  6  one-hot {B,R,J,S,U,I}, all-zero when illegal
- out_wb  out  1  writes rd
- out_ld, out_st, out_br, out_jal, out_jalr, out_sys  out  1 each  class flags
- out_w  out  1  OP-32/OP-IMM-32 word op
- out_call, out_ret  out  1 each  RAS push/pop hints
- out_ebreak, out_illegal  out  1 each  exception flags
- count  out  $clog2(QDEPTH+1)  queue occupancy

## Operation
- Decode is combinational on in_inst. The result is written into the queue at tail on push = in_vld & in_rdy & ~flush.
- pop = out_vld & out_rdy. The head advances and the entry is freed.
- in_rdy = (count < QDEPTH). It never depends on out_rdy.
- out_vld = (count != 0). out_* data fields show the head entry and are don't-care when out_vld = 0.
- Pointers wrap modulo QDEPTH. count tracks +push −pop. Simultaneous push and pop leaves count unchanged.
- Immediate formats:
  - I: {inst[31:20]}
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - All formats are sign-extended from inst[31] to XLEN.
- Opcode to format mapping:
  - I: OP-IMM, OP-IMM-32, JALR, LOAD, SYSTEM
  - U: LUI, AUIPC
  - S: STORE
  - J: JAL
  - R: OP, OP-32
  - B: BRANCH
- out_wb = R | J | U | (I & ~(SYSTEM & funct3 == 0)).
- Link registers are x1 and x5.
  - out_call = (JAL & rd_link) | (JALR & rd_link).
  - out_ret = JALR & rs1_link & (~rd_link | rs1 != rd).
  - JALR with rd_link, rs1_link and rs1 != rd asserts both out_call and out_ret.
- out_ebreak = SYSTEM & funct3 == 0 & inst[21:20] == 01.
- out_illegal is set when any of the following holds:
  - inst[1:0] != 11
  - the opcode is outside the set above
  - XLEN = 32 and (OP-32 | OP-IMM-32 | LD/SD/LWU funct3 ∈ {011, 110})
  - XLEN = 32 and shift-immediate with inst[25] = 1
- Illegal entries are still queued in order, with out_illegal = 1 and all class flags and out_wb forced to 0.

## Timing
- Latency: instruction pushed at edge N appears at out_vld after edge N when the queue was empty (1 cycle).
- Throughput: 1 per cycle for QDEPTH ≥ 2 with out_rdy held high. With QDEPTH = 1 it is 1 per 2 cycles.
- Full queue with pop in the same cycle: pop happens, push is refused because in_rdy = 0. in_rdy rises the next cycle.
- flush: at the next edge count = 0 and head = tail = 0. Any input presented in the flush cycle is dropped, even if in_rdy = 1. A pop in the flush cycle still completes, so out_vld/out_rdy remain a legal handshake.
- Reset (asserted at any time, mid-stream included): immediate, asynchronous.
  - count = 0, pointers = 0, out_vld = 0, so in_rdy = 1.
  - out_pc = RESET_PC; all other out_* = 0.
  - Queue contents are not cleared, but are unobservable.
- Deassertion of rst_n is synchronised by the system; the first push may occur on the first edge after release.

## Test plan
- XLEN = 64: push 0x00500093 (addi x1,x0,5) at pc 0x80000000 → next cycle out_vld = 1, rd = 1, rs1 = 0, imm = 5, fmt = I, wb = 1, illegal = 0.
- lui 0x800002B7 → imm = 0xFFFFFFFF80000000, rd = 5, fmt = U. Same word with XLEN = 32 → imm = 0x80000000.
- Calls and returns:
  - 0x008000EF (jal x1,8) → call = 1, ret = 0, imm = 8.
  - 0x00008067 (ret) → ret = 1, call = 0, wb = 1.
  - 0x000280E7 (jalr x1,0(x5)) → call = 1 and ret = 1.
- Backpressure with QDEPTH = 2: out_rdy = 0, push 3 words → in_rdy low after 2 and count = 2. Raise out_rdy → entries emerge in order, in_rdy returns the cycle after the first pop.
- Flush with count = 2 and in_vld = 1 → next cycle count = 0, out_vld = 0, and the offered word never appears.
- Illegal and exception cases:
  - 0x0000003B (addw) with XLEN = 32 → illegal = 1, wb = 0.
  - 0xFFFFFFFF → illegal = 1.
  - 0x00100073 → ebreak = 1, wb = 0.
  - Assert rst_n low mid-stream → out_vld drops immediately and out_pc = 0x80000000.

Source files
------------

// File: rtl/idu_pipe.sv
// idu_pipe: RV32I/RV64I(M) decode stage. Instructions from fetch are decoded
// combinationally and written into a small FIFO. Execute consumes entries from
// the FIFO head, so stalls in execute never reach fetch combinationally.
module idu_pipe #(
    parameter int          XLEN     = 64,
    parameter int          QDEPTH   = 2,
    parameter logic [63:0] RESET_PC = 64'h80000000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_vld,
    output logic                        in_rdy,
    input  logic [31:0]                 in_inst,
    input  logic [XLEN-1:0]             in_pc,
    output logic                        out_vld,
    input  logic                        out_rdy,
    output logic [XLEN-1:0]             out_pc,
    output logic [31:0]                 out_inst,
    output logic [4:0]                  out_rd,
    output logic [4:0]                  out_rs1,
    output logic [4:0]                  out_rs2,
    output logic [XLEN-1:0]             out_imm,
    output logic [5:0]                  out_fmt,
    output logic                        out_wb,
    output logic                        out_ld,
    output logic                        out_st,
    output logic                        out_br,
    output logic                        out_jal,
    output logic                        out_jalr,
    output logic                        out_sys,
    output logic                        out_w,
    output logic                        out_call,
    output logic                        out_ret,
    output logic                        out_ebreak,
    output logic                        out_illegal,
    output logic [$clog2(QDEPTH+1)-1:0] count
);

    localparam int            CW       = $clog2(QDEPTH + 1);
    localparam int            PW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(QDEPTH - 1);
    localparam bit            RV32     = (XLEN == 32);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Handshake: a transfer happens on a rising edge when valid and ready are
    // both high in the preceding cycle. in_rdy depends only on occupancy and
    // out_vld only on occupancy; neither looks at the opposite side's ready,
    // and a flush cycle drops the offered input regardless of in_rdy.

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] imm;
        logic [5:0]      fmt;
        logic            wb;
        logic            ld;
        logic            st;
        logic            br;
        logic            jal;
        logic            jalr;
        logic            sys;
        logic            w;
        logic            call;
        logic            ret;
        logic            ebreak;
        logic            illegal;
    } entry_t;

    // ---------------- decode ----------------
    logic [6:0] opc;
    logic [2:0] funct3;
    logic [4:0] rd_idx;
    logic [4:0] rs1_idx;
    logic       is_load, is_op_imm, is_auipc, is_op_imm32, is_store, is_op;
    logic       is_lui, is_op32, is_branch, is_jalr, is_jal, is_system;
    logic       fmt_i, fmt_u, fmt_s, fmt_j, fmt_r, fmt_b;
    logic       known_opc, rv32_bad, legal;
    logic       rd_link, rs1_link;

    assign opc     = in_inst[6:0];
    assign funct3  = in_inst[14:12];
    assign rd_idx  = in_inst[11:7];
    assign rs1_idx = in_inst[19:15];

    assign is_load     = (opc == OPC_LOAD);
    assign is_op_imm   = (opc == OPC_OP_IMM);
    assign is_auipc    = (opc == OPC_AUIPC);
    assign is_op_imm32 = (opc == OPC_OP_IMM32);
    assign is_store    = (opc == OPC_STORE);
    assign is_op       = (opc == OPC_OP);
    assign is_lui      = (opc == OPC_LUI);
    assign is_op32     = (opc == OPC_OP32);
    assign is_branch   = (opc == OPC_BRANCH);
    assign is_jalr     = (opc == OPC_JALR);
    assign is_jal      = (opc == OPC_JAL);
    assign is_system   = (opc == OPC_SYSTEM);

    assign fmt_i = is_op_imm | is_op_imm32 | is_jalr | is_load | is_system;
    assign fmt_u = is_lui | is_auipc;
    assign fmt_s = is_store;
    assign fmt_j = is_jal;
    assign fmt_r = is_op | is_op32;
    assign fmt_b = is_branch;

    assign known_opc = fmt_i | fmt_u | fmt_s | fmt_j | fmt_r | fmt_b;

    // RV64-only encodings that an RV32 core must trap on: word ops,
    // LD/SD/LWU and shift-immediates with a 6-bit shamt.
    assign rv32_bad = RV32 & (is_op32 | is_op_imm32
                    | ((is_load | is_store) & ((funct3 == 3'b011) | (funct3 == 3'b110)))
                    | (is_op_imm & ((funct3 == 3'b001) | (funct3 == 3'b101)) & in_inst[25]));

    assign legal = (in_inst[1:0] == 2'b11) & known_opc & ~rv32_bad;

    assign rd_link  = (rd_idx == 5'd1) | (rd_idx == 5'd5);
    assign rs1_link = (rs1_idx == 5'd1) | (rs1_idx == 5'd5);

    entry_t dec;

    // Build the decoded entry; illegal words keep pc/inst but lose all class flags.
    always_comb begin
        dec      = '0;
        dec.pc   = in_pc;
        dec.inst = in_inst;
        if (fmt_i)
            dec.imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
        else if (fmt_s)
            dec.imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        else if (fmt_b)
            dec.imm = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                       in_inst[30:25], in_inst[11:8], 1'b0};
        else if (fmt_u)
            dec.imm = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
        else if (fmt_j)
            dec.imm = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                       in_inst[20], in_inst[30:21], 1'b0};
        dec.illegal = ~legal;
        if (legal) begin
            dec.fmt    = {fmt_b, fmt_r, fmt_j, fmt_s, fmt_u, fmt_i};
            dec.wb     = fmt_r | fmt_j | fmt_u | (fmt_i & ~(is_system & (funct3 == 3'b000)));
            dec.ld     = is_load;
            dec.st     = is_store;
            dec.br     = is_branch;
            dec.jal    = is_jal;
            dec.jalr   = is_jalr;
            dec.sys    = is_system;
            dec.w      = is_op32 | is_op_imm32;
            dec.call   = (is_jal | is_jalr) & rd_link;
            dec.ret    = is_jalr & rs1_link & (~rd_link | (rs1_idx != rd_idx));
            dec.ebreak = is_system & (funct3 == 3'b000) & (in_inst[21:20] == 2'b01);
        end
    end

    // ---------------- queue ----------------
    entry_t        mem [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push;
    logic          pop;

    assign in_rdy  = (count < CW'(QDEPTH));
    assign out_vld = (count != '0);
    assign push    = in_vld & in_rdy & ~flush;
    assign pop     = out_vld & out_rdy;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Storage has no reset; stale entries are hidden behind count == 0.
    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= dec;
    end

    // Pointers and occupancy; flush empties the queue, push is already gated by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= next_ptr(tail);
            if (pop)
                head <= next_ptr(head);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // ---------------- head presentation ----------------
    entry_t shown;

    // An empty queue shows the reset pattern so outputs are defined in and after reset.
    always_comb begin
        shown    = '0;
        shown.pc = RESET_PC[XLEN-1:0];
        if (out_vld)
            shown = mem[head];
    end

    assign out_pc      = shown.pc;
    assign out_inst    = shown.inst;
    assign out_rd      = shown.inst[11:7];
    assign out_rs1     = shown.inst[19:15];
    assign out_rs2     = shown.inst[24:20];
    assign out_imm     = shown.imm;
    assign out_fmt     = shown.fmt;
    assign out_wb      = shown.wb;
    assign out_ld      = shown.ld;
    assign out_st      = shown.st;
    assign out_br      = shown.br;
    assign out_jal     = shown.jal;
    assign out_jalr    = shown.jalr;
    assign out_sys     = shown.sys;
    assign out_w       = shown.w;
    assign out_call    = shown.call;
    assign out_ret     = shown.ret;
    assign out_ebreak  = shown.ebreak;
    assign out_illegal = shown.illegal;

endmodule

// File: tb/tb_idu_pipe.sv
// tb_idu_pipe: two decoders (XLEN 64 and XLEN 32, QDEPTH 2) share one input
// stream. Table vectors, hand sequences for backpressure/flush/reset, then a
// randomized run against a reference decoder and an ordered expectation queue.
module tb_idu_pipe;

    localparam int QD = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        in_vld;
    logic        out_rdy;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    logic        in_rdy_a, out_vld_a, wb_a, ld_a, st_a, br_a, jal_a, jalr_a, sys_a, w_a;
    logic        call_a, ret_a, ebreak_a, ill_a;
    logic [63:0] out_pc_a, imm_a;
    logic [31:0] out_inst_a;
    logic [4:0]  rd_a, rs1_a, rs2_a;
    logic [5:0]  fmt_a;
    logic [1:0]  cnt_a;

    logic        in_rdy_b, out_vld_b, wb_b, ld_b, st_b, br_b, jal_b, jalr_b, sys_b, w_b;
    logic        call_b, ret_b, ebreak_b, ill_b;
    logic [31:0] out_pc_b, imm_b;
    logic [31:0] out_inst_b;
    logic [4:0]  rd_b, rs1_b, rs2_b;
    logic [5:0]  fmt_b;
    logic [1:0]  cnt_b;

    idu_pipe #(.XLEN(64), .QDEPTH(QD), .RESET_PC(64'h80000000)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy_a),
        .in_inst(in_inst), .in_pc(in_pc), .out_vld(out_vld_a), .out_rdy(out_rdy),
        .out_pc(out_pc_a), .out_inst(out_inst_a), .out_rd(rd_a), .out_rs1(rs1_a),
        .out_rs2(rs2_a), .out_imm(imm_a), .out_fmt(fmt_a), .out_wb(wb_a), .out_ld(ld_a),
        .out_st(st_a), .out_br(br_a), .out_jal(jal_a), .out_jalr(jalr_a), .out_sys(sys_a),
        .out_w(w_a), .out_call(call_a), .out_ret(ret_a), .out_ebreak(ebreak_a),
        .out_illegal(ill_a), .count(cnt_a));

    idu_pipe #(.XLEN(32), .QDEPTH(QD), .RESET_PC(64'h80000000)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy_b),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_vld(out_vld_b), .out_rdy(out_rdy),
        .out_pc(out_pc_b), .out_inst(out_inst_b), .out_rd(rd_b), .out_rs1(rs1_b),
        .out_rs2(rs2_b), .out_imm(imm_b), .out_fmt(fmt_b), .out_wb(wb_b), .out_ld(ld_b),
        .out_st(st_b), .out_br(br_b), .out_jal(jal_b), .out_jalr(jalr_b), .out_sys(sys_b),
        .out_w(w_b), .out_call(call_b), .out_ret(ret_b), .out_ebreak(ebreak_b),
        .out_illegal(ill_b), .count(cnt_b));

    // Observed outputs of each DUT in one common shape; flags are
    // {wb, ld, st, br, jal, jalr, sys, w, call, ret, ebreak, illegal}.
    typedef struct packed {
        logic        vld;
        logic        rdy;
        logic [1:0]  cnt;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic [5:0]  fmt;
        logic [11:0] flags;
    } obs_t;

    obs_t oa, ob;

    always_comb begin
        oa       = '0;
        oa.vld   = out_vld_a;
        oa.rdy   = in_rdy_a;
        oa.cnt   = cnt_a;
        oa.pc    = out_pc_a;
        oa.inst  = out_inst_a;
        oa.rd    = rd_a;
        oa.rs1   = rs1_a;
        oa.rs2   = rs2_a;
        oa.imm   = imm_a;
        oa.fmt   = fmt_a;
        oa.flags = {wb_a, ld_a, st_a, br_a, jal_a, jalr_a, sys_a, w_a, call_a, ret_a, ebreak_a, ill_a};
    end

    always_comb begin
        ob       = '0;
        ob.vld   = out_vld_b;
        ob.rdy   = in_rdy_b;
        ob.cnt   = cnt_b;
        ob.pc    = {32'h0, out_pc_b};
        ob.inst  = out_inst_b;
        ob.rd    = rd_b;
        ob.rs1   = rs1_b;
        ob.rs2   = rs2_b;
        ob.imm   = {32'h0, imm_b};
        ob.fmt   = fmt_b;
        ob.flags = {wb_b, ld_b, st_b, br_b, jal_b, jalr_b, sys_b, w_b, call_b, ret_b, ebreak_b, ill_b};
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [95:0] exp_q[$];   // {inst, pc} in expected output order

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference decoder ----------------
    typedef struct packed {
        logic [63:0] imm;
        logic [5:0]  fmt;
        logic [11:0] flags;
    } dec_t;

    function automatic dec_t ref_decode(input logic [31:0] inst, input bit rv32);
        dec_t              d;
        logic signed [63:0] s;
        logic [6:0]        op;
        logic [2:0]        f3;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        bit                legal, rd_lnk, rs1_lnk, i_fmt, wb;
        op    = inst[6:0];
        f3    = inst[14:12];
        rd    = inst[11:7];
        rs1   = inst[19:15];
        s     = $signed({inst, 32'h0});   // inst[31] is the sign bit of s
        d     = '0;
        legal = 1'b1;
        i_fmt = 1'b0;
        case (op)
            7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: begin
                d.fmt = 6'b000001; i_fmt = 1'b1;
                d.imm = 64'(s >>> 52);
            end
            7'h37, 7'h17: begin
                d.fmt = 6'b000010;
                d.imm = 64'(s >>> 44) << 12;
            end
            7'h23: begin
                d.fmt = 6'b000100;
                d.imm = (64'(s >>> 57) << 5) | 64'(inst[11:7]);
            end
            7'h6F: begin
                d.fmt = 6'b001000;
                d.imm = (64'(s >>> 63) << 20) | (64'(inst[19:12]) << 12)
                      | (64'(inst[20]) << 11) | (64'(inst[30:21]) << 1);
            end
            7'h33, 7'h3B: d.fmt = 6'b010000;
            7'h63: begin
                d.fmt = 6'b100000;
                d.imm = (64'(s >>> 63) << 12) | (64'(inst[7]) << 11)
                      | (64'(inst[30:25]) << 5) | (64'(inst[11:8]) << 1);
            end
            default: legal = 1'b0;
        endcase
        if (rv32 && (op == 7'h3B || op == 7'h1B)) legal = 1'b0;
        if (rv32 && (op == 7'h03 || op == 7'h23) && (f3 == 3'd3 || f3 == 3'd6)) legal = 1'b0;
        if (rv32 && op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5) && inst[25]) legal = 1'b0;
        rd_lnk  = (rd == 5'd1) || (rd == 5'd5);
        rs1_lnk = (rs1 == 5'd1) || (rs1 == 5'd5);
        if (legal) begin
            wb = d.fmt[4] || d.fmt[3] || d.fmt[1] || (i_fmt && !(op == 7'h73 && f3 == 3'd0));
            d.flags = {wb, op == 7'h03, op == 7'h23, op == 7'h63, op == 7'h6F, op == 7'h67,
                       op == 7'h73, (op == 7'h3B) || (op == 7'h1B),
                       ((op == 7'h6F) || (op == 7'h67)) && rd_lnk,
                       (op == 7'h67) && rs1_lnk && (!rd_lnk || rs1 != rd),
                       (op == 7'h73) && (f3 == 3'd0) && (inst[21:20] == 2'b01),
                       1'b0};
        end else begin
            d.fmt   = '0;
            d.flags = 12'h001;
        end
        return d;
    endfunction

    task automatic chk_head(input obs_t o, input bit rv32, input logic [95:0] e);
        dec_t        d;
        logic [31:0] inst;
        logic [63:0] mask;
        string       t;
        inst = e[95:64];
        mask = rv32 ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        d    = ref_decode(inst, rv32);
        t    = rv32 ? "x32" : "x64";
        chk({t, ".pc"},    o.pc, e[63:0] & mask);
        chk({t, ".inst"},  o.inst, inst);
        chk({t, ".regs"},  {o.rd, o.rs1, o.rs2}, {inst[11:7], inst[19:15], inst[24:20]});
        chk({t, ".fmt"},   o.fmt, d.fmt);
        chk({t, ".flags"}, o.flags, d.flags);
        if (!d.flags[0])
            chk({t, ".imm"}, o.imm, d.imm & mask);
    endtask

    task automatic check_state();
        chk("x64.count", o_cnt(oa), exp_q.size());
        chk("x32.count", o_cnt(ob), exp_q.size());
        chk("x64.out_vld", oa.vld, exp_q.size() != 0);
        chk("x32.out_vld", ob.vld, exp_q.size() != 0);
        chk("x64.in_rdy", oa.rdy, exp_q.size() < QD);
        chk("x32.in_rdy", ob.rdy, exp_q.size() < QD);
        if (exp_q.size() != 0) begin
            chk_head(oa, 1'b0, exp_q[0]);
            chk_head(ob, 1'b1, exp_q[0]);
        end
    endtask

    function automatic logic [63:0] o_cnt(input obs_t o);
        return 64'(o.cnt);
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [4:0] link_reg();
        case ($urandom_range(0, 2))
            0:       return 5'd0;
            1:       return 5'd1;
            default: return 5'd5;
        endcase
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 13))
            0:  r[6:0] = 7'h03;
            1:  r[6:0] = 7'h13;
            2:  r[6:0] = 7'h17;
            3:  r[6:0] = 7'h1B;
            4:  r[6:0] = 7'h23;
            5:  r[6:0] = 7'h33;
            6:  r[6:0] = 7'h37;
            7:  r[6:0] = 7'h3B;
            8:  r[6:0] = 7'h63;
            9:  r[6:0] = 7'h67;
            10: r[6:0] = 7'h6F;
            11: r[6:0] = 7'h73;
            default: ;
        endcase
        if ($urandom_range(0, 1) == 1) begin
            r[11:7]  = link_reg();
            r[19:15] = link_reg();
        end
        if (r[6:0] == 7'h73 && $urandom_range(0, 1) == 1) begin
            r[14:12] = 3'd0;
            r[31:20] = 12'($urandom_range(0, 1));
        end
        return r;
    endfunction

    // ---------------- table vectors ----------------
    typedef struct {
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [63:0] imm64;
        logic [63:0] imm32;
        logic [5:0]  fmt64;
        logic [5:0]  fmt32;
        logic        wb64;
        logic        wb32;
        logic        call;
        logic        ret;
        logic        ebreak;
        logic        ill64;
        logic        ill32;
    } vec_t;

    vec_t vt[12];

    task automatic tab_chk(input int i, input obs_t o, input bit rv32, input logic [63:0] pc);
        string t;
        logic  ill;
        t   = $sformatf("tab%0d.%s", i, rv32 ? "x32" : "x64");
        ill = rv32 ? vt[i].ill32 : vt[i].ill64;
        chk({t, ".vld"},    o.vld, 1);
        chk({t, ".count"},  o_cnt(o), 1);
        chk({t, ".pc"},     o.pc, rv32 ? (pc & 64'hFFFF_FFFF) : pc);
        chk({t, ".rd"},     o.rd, vt[i].rd);
        chk({t, ".rs1"},    o.rs1, vt[i].rs1);
        chk({t, ".fmt"},    o.fmt, rv32 ? vt[i].fmt32 : vt[i].fmt64);
        chk({t, ".wb"},     o.flags[11], rv32 ? vt[i].wb32 : vt[i].wb64);
        chk({t, ".call"},   o.flags[3], vt[i].call);
        chk({t, ".ret"},    o.flags[2], vt[i].ret);
        chk({t, ".ebreak"}, o.flags[1], vt[i].ebreak);
        chk({t, ".illegal"}, o.flags[0], ill);
        if (!ill)
            chk({t, ".imm"}, o.imm, rv32 ? vt[i].imm32 : vt[i].imm64);
    endtask

    task automatic reset_chk(input string t);
        chk({t, ".x64.out_vld"}, oa.vld, 0);
        chk({t, ".x32.out_vld"}, ob.vld, 0);
        chk({t, ".x64.in_rdy"},  oa.rdy, 1);
        chk({t, ".x32.in_rdy"},  ob.rdy, 1);
        chk({t, ".x64.count"},   o_cnt(oa), 0);
        chk({t, ".x64.out_pc"},  oa.pc, 64'h80000000);
        chk({t, ".x32.out_pc"},  ob.pc, 64'h80000000);
        chk({t, ".x64.inst"},    oa.inst, 0);
        chk({t, ".x64.flags"},   oa.flags, 0);
        chk({t, ".x32.fmt"},     ob.fmt, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic pop, push;
        rst_n   = 1'b0;
        flush   = 1'b0;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        in_inst = '0;
        in_pc   = '0;

        vt[0]  = '{32'h00500093, 5'd1,  5'd0,  64'd5, 64'd5, 6'h01, 6'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{32'h800002B7, 5'd5,  5'd0,  64'hFFFF_FFFF_8000_0000, 64'h8000_0000,
                   6'h02, 6'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{32'h008000EF, 5'd1,  5'd0,  64'd8, 64'd8, 6'h08, 6'h08, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{32'h00008067, 5'd0,  5'd1,  64'd0, 64'd0, 6'h01, 6'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{32'h000280E7, 5'd1,  5'd5,  64'd0, 64'd0, 6'h01, 6'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{32'h0000003B, 5'd0,  5'd0,  64'd0, 64'd0, 6'h10, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{32'hFFFFFFFF, 5'd31, 5'd31, 64'd0, 64'd0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[7]  = '{32'h00100073, 5'd0,  5'd0,  64'd1, 64'd1, 6'h01, 6'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{32'h00003083, 5'd1,  5'd0,  64'd0, 64'd0, 6'h01, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{32'h02009093, 5'd1,  5'd1,  64'h20, 64'h20, 6'h01, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[10] = '{32'h00000010, 5'd0,  5'd0,  64'd0, 64'd0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[11] = '{32'hFE000EE3, 5'd29, 5'd0,  64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFC,
                   6'h20, 6'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // reset values while rst_n is held low
        #12;
        reset_chk("reset");
        tick();
        rst_n = 1'b1;

        // table: push one word, inspect the head, pop it
        for (int i = 0; i < 12; i++) begin
            in_vld  = 1'b1;
            in_inst = vt[i].inst;
            in_pc   = 64'h80000000 + 64'(4 * i);
            out_rdy = 1'b0;
            tick();
            in_vld = 1'b0;
            tab_chk(i, oa, 1'b0, 64'h80000000 + 64'(4 * i));
            tab_chk(i, ob, 1'b1, 64'h80000000 + 64'(4 * i));
            out_rdy = 1'b1;
            tick();
            out_rdy = 1'b0;
            chk($sformatf("tab%0d.drained", i), o_cnt(oa), 0);
        end

        // backpressure: three words offered with out_rdy low
        in_vld = 1'b1; in_inst = 32'h00100093; in_pc = 64'h1000;
        tick();
        chk("bp.count1", o_cnt(oa), 1);
        chk("bp.rdy1", oa.rdy, 1);
        in_inst = 32'h00200113; in_pc = 64'h1004;
        tick();
        chk("bp.count2", o_cnt(oa), 2);
        chk("bp.rdy_full.x64", oa.rdy, 0);
        chk("bp.rdy_full.x32", ob.rdy, 0);
        in_inst = 32'h00300193; in_pc = 64'h1008;
        tick();
        chk("bp.held_count", o_cnt(oa), 2);
        chk("bp.held_head", oa.inst, 32'h00100093);
        out_rdy = 1'b1;
        tick();
        chk("bp.pop1_count", o_cnt(oa), 1);
        chk("bp.pop1_rdy", oa.rdy, 1);
        chk("bp.pop1_head", oa.inst, 32'h00200113);
        tick();
        in_vld = 1'b0;
        chk("bp.pop2_count", o_cnt(oa), 1);
        chk("bp.pop2_head", oa.inst, 32'h00300193);
        chk("bp.pop2_pc", oa.pc, 64'h1008);
        tick();
        out_rdy = 1'b0;
        chk("bp.empty", oa.vld, 0);

        // flush with a full queue and a word on the input
        in_vld = 1'b1; in_inst = 32'h00400213; in_pc = 64'h2000;
        tick();
        in_inst = 32'h00500293; in_pc = 64'h2004;
        tick();
        chk("fl.full", o_cnt(oa), 2);
        in_inst = 32'h00600313; in_pc = 64'h2008; flush = 1'b1;
        tick();
        flush = 1'b0; in_vld = 1'b0;
        chk("fl.count.x64", o_cnt(oa), 0);
        chk("fl.count.x32", o_cnt(ob), 0);
        chk("fl.vld", oa.vld, 0);
        chk("fl.rdy", oa.rdy, 1);
        out_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fl.stays_empty%0d", k), oa.vld, 0);
        end
        out_rdy = 1'b0;

        // flush with room in the queue still drops the offered word
        in_vld = 1'b1; in_inst = 32'h00700393; in_pc = 64'h3000;
        tick();
        in_inst = 32'h00800413; flush = 1'b1;
        tick();
        flush = 1'b0; in_vld = 1'b0;
        chk("fl2.count", o_cnt(oa), 0);
        tick();
        chk("fl2.still_empty", o_cnt(ob), 0);

        // asynchronous reset in the middle of a cycle
        in_vld = 1'b1; in_inst = 32'h00900493; in_pc = 64'h4000;
        tick();
        in_vld = 1'b0;
        chk("mr.before", oa.vld, 1);
        #2;
        rst_n = 1'b0;
        #1;
        reset_chk("midreset");
        tick();
        rst_n   = 1'b1;
        in_vld  = 1'b1; in_inst = 32'h00A00513; in_pc = 64'h5000;
        tick();
        in_vld = 1'b0;
        chk("mr.first_push_vld", oa.vld, 1);
        chk("mr.first_push_inst", oa.inst, 32'h00A00513);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("mr.drained", o_cnt(oa), 0);

        // randomized traffic against the reference model
        exp_q.delete();
        for (int cyc = 0; cyc < 800; cyc++) begin
            check_state();
            in_vld  = ($urandom_range(0, 3) != 0);
            in_inst = rand_inst();
            in_pc   = {$urandom(), $urandom()};
            out_rdy = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 40) == 0);
            pop  = (exp_q.size() != 0) && out_rdy;
            push = in_vld && (exp_q.size() < QD) && !flush;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (pop)
                    void'(exp_q.pop_front());
                if (push)
                    exp_q.push_back({in_inst, in_pc});
            end
            tick();
        end
        check_state();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
